// File: rtl/fifo_ctrl.sv
// Pointer/flag controller wrapping a single-port-pair RAM as a synchronous FIFO.
// Define FIFO_CTRL_ALMOST_EN to build the almost_full/almost_empty threshold flags.
module fifo_ctrl #(
  parameter int RAM_DEPTH     = 256,
  parameter int ADDER_SIZE    = 8,
  parameter int AFULL_THRESH  = 240,
  parameter int AEMPTY_THRESH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  output logic                  wr_enb,
  output logic                  rd_enb,
  output logic [ADDER_SIZE-1:0] wr_addr,
  output logic [ADDER_SIZE-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [ADDER_SIZE:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDER_SIZE:0] ONE      = (ADDER_SIZE+1)'(1);
  localparam logic [ADDER_SIZE:0] FULL_CNT = (ADDER_SIZE+1)'(RAM_DEPTH);

  // Elaboration-time parameter sanity checks.
  if (RAM_DEPTH != (1 << ADDER_SIZE)) begin : g_bad_depth
    $error("fifo_ctrl: RAM_DEPTH must equal 2**ADDER_SIZE");
  end
  if (AFULL_THRESH > RAM_DEPTH || AEMPTY_THRESH > RAM_DEPTH) begin : g_bad_thresh
    $error("fifo_ctrl: thresholds must not exceed RAM_DEPTH");
  end

  logic [ADDER_SIZE:0] wr_ptr;
  logic [ADDER_SIZE:0] rd_ptr;
  logic [ADDER_SIZE:0] count_next;

  // Enables are blocked in reset so no RAM write can slip through.
  assign wr_enb  = push & ~full  & ~reset;
  assign rd_enb  = pop  & ~empty & ~reset;
  assign wr_addr = wr_ptr[ADDER_SIZE-1:0];
  assign rd_addr = rd_ptr[ADDER_SIZE-1:0];

  always_comb begin
    count_next = count;
    case ({wr_enb, rd_enb})
      2'b10:   count_next = count + ONE;
      2'b01:   count_next = count - ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_enb) wr_ptr <= wr_ptr + ONE;
      if (rd_enb) rd_ptr <= rd_ptr + ONE;
      count    <= count_next;
      full     <= (count_next == FULL_CNT);
      empty    <= (count_next == '0);
      rd_valid <= rd_enb;
      // Error flags are sticky until reset.
      if (push && full)  overflow  <= 1'b1;
      if (pop  && empty) underflow <= 1'b1;
    end
  end

`ifdef FIFO_CTRL_ALMOST_EN
  localparam logic [ADDER_SIZE:0] AF_CNT = (ADDER_SIZE+1)'(AFULL_THRESH);
  localparam logic [ADDER_SIZE:0] AE_CNT = (ADDER_SIZE+1)'(AEMPTY_THRESH);

  always_ff @(posedge clk) begin
    if (reset) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_next >= AF_CNT);
      almost_empty <= (count_next <= AE_CNT);
    end
  end
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl (depth 8): table of per-cycle vectors plus
// hand-written wrap/data-order, collision and mid-burst reset sequences.
module tb_fifo_ctrl;

`ifdef FIFO_CTRL_ALMOST_EN
  localparam bit ALM = 1'b1;
`else
  localparam bit ALM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, push, pop;
  logic       wr_enb, rd_enb, rd_valid, full, empty;
  logic       almost_full, almost_empty, overflow, underflow;
  logic [2:0] wr_addr, rd_addr;
  logic [3:0] count;

  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic [7:0] mem [0:7];
  logic [7:0] exp_q [$];
  bit         data_chk = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(
    .RAM_DEPTH(8), .ADDER_SIZE(3), .AFULL_THRESH(6), .AEMPTY_THRESH(1)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .wr_enb(wr_enb), .rd_enb(rd_enb), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  // Behavioural RAM: write on wr_enb, registered read on rd_enb.
  always @(posedge clk) begin
    if (wr_enb) mem[wr_addr] <= din;
    if (rd_enb) dout <= mem[rd_addr];
  end

  typedef struct {
    logic r, p, q;
    logic wen, ren;
    logic [2:0] wa, ra;
    logic [3:0] cnt;
    logic fl, em, af, ae, ov, un, rv;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(int r, int p, int q, int wen, int ren, int wa, int ra,
                              int cnt, int fl, int em, int af, int ae, int ov, int un, int rv);
    vec_t v;
    v.r = 1'(r); v.p = 1'(p); v.q = 1'(q);
    v.wen = 1'(wen); v.ren = 1'(ren); v.wa = 3'(wa); v.ra = 3'(ra);
    v.cnt = 4'(cnt); v.fl = 1'(fl); v.em = 1'(em); v.af = 1'(af); v.ae = 1'(ae);
    v.ov = 1'(ov); v.un = 1'(un); v.rv = 1'(rv);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic p, input logic q);
    @(negedge clk);
    reset = r; push = p; pop = q;
    din = din + 8'h11;
    if (data_chk && p && !r) exp_q.push_back(din);
    #1;
  endtask

  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (data_chk && rd_valid) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk("data_order", int'(dout), int'(e));
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_afull"}, almost_full, 0);
    chk({tag, "_aempty"}, almost_empty, int'(ALM));
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_udf"}, underflow, 0);
    chk({tag, "_rvalid"}, rd_valid, 0);
    chk({tag, "_waddr"}, wr_addr, 0);
    chk({tag, "_raddr"}, rd_addr, 0);
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0;

    // Reset held two cycles (second with requests active), fill, overflow,
    // drain, underflow, then push+pop on an empty FIFO.
    tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,1,0,1,0,0,0));
    tbl.push_back(mk(1,1,1, 0,0,0,0, 0,0,1,0,1,0,0,0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(0,1,0, 1,0,k-1,0, k,int'(k==8),0,int'(k>=6),int'(k<=1),0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,0,0, 8,1,0,1,0,1,0,0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(0,0,1, 0,1,0,k-1, 8-k,0,int'(k==8),int'(k<=2),int'(k>=7),1,0,1));
    tbl.push_back(mk(0,0,1, 0,0,0,0, 0,0,1,0,1,1,1,0));
    tbl.push_back(mk(0,1,1, 1,0,0,0, 1,0,0,0,1,1,1,0));

    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].p, tbl[i].q);
      chk($sformatf("v%0d_wr_enb", i), wr_enb, tbl[i].wen);
      chk($sformatf("v%0d_rd_enb", i), rd_enb, tbl[i].ren);
      chk($sformatf("v%0d_wr_addr", i), wr_addr, tbl[i].wa);
      chk($sformatf("v%0d_rd_addr", i), rd_addr, tbl[i].ra);
      tick();
      chk($sformatf("v%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("v%0d_full", i), full, tbl[i].fl);
      chk($sformatf("v%0d_empty", i), empty, tbl[i].em);
      chk($sformatf("v%0d_afull", i), almost_full, int'(ALM & tbl[i].af));
      chk($sformatf("v%0d_aempty", i), almost_empty, int'(ALM & tbl[i].ae));
      chk($sformatf("v%0d_ovf", i), overflow, tbl[i].ov);
      chk($sformatf("v%0d_udf", i), underflow, tbl[i].un);
      chk($sformatf("v%0d_rvalid", i), rd_valid, tbl[i].rv);
    end

    // Wrap with sustained push+pop at count 3, checking read data order.
    drive(1, 0, 0);
    tick();
    chk_reset_state("wrap_rst");
    data_chk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1);
      chk($sformatf("wrap%0d_wr_enb", i), wr_enb, 1);
      chk($sformatf("wrap%0d_rd_enb", i), rd_enb, 1);
      chk($sformatf("wrap%0d_wr_addr", i), wr_addr, (3 + i) % 8);
      chk($sformatf("wrap%0d_rd_addr", i), rd_addr, i % 8);
      tick();
      chk($sformatf("wrap%0d_count", i), count, 3);
    end
    drive(0, 0, 0);
    tick();
    chk("wrap_data_remaining", exp_q.size(), 3);
    data_chk = 1'b0;

    // Underflow, pop right after the first push, full collision, mid-burst reset.
    drive(1, 0, 0);
    tick();
    drive(0, 0, 1);
    chk("udf_rd_enb", rd_enb, 0);
    tick();
    chk("udf_flag", underflow, 1);
    chk("udf_rvalid", rd_valid, 0);
    drive(0, 1, 0);
    tick();
    drive(0, 0, 1);
    chk("pop_after_first_push_rd_enb", rd_enb, 1);
    tick();
    chk("pop_after_first_push_rvalid", rd_valid, 1);
    chk("pop_after_first_push_empty", empty, 1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0);
      tick();
    end
    chk("coll_pre_full", full, 1);
    drive(0, 1, 1);
    chk("coll_full_wr_enb", wr_enb, 0);
    chk("coll_full_rd_enb", rd_enb, 1);
    tick();
    chk("coll_full_count", count, 7);
    chk("coll_full_full", full, 0);
    chk("coll_full_ovf", overflow, 1);
    chk("coll_full_udf_sticky", underflow, 1);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1);
      tick();
    end
    chk("midrst_pre_count", count, 5);
    drive(1, 1, 1);
    chk("midrst_wr_enb", wr_enb, 0);
    chk("midrst_rd_enb", rd_enb, 0);
    tick();
    chk_reset_state("midrst");

    drive(0, 0, 0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller that turns the single-port-pair RAM macro into a synchronous FIFO. Sits directly upstream of the RAM. It accepts push/pop requests from the producer/consumer, drives the RAM's write/read enables and addresses, and reports occupancy and status. Write data passes straight from the producer to the RAM `data_in`. Read data appears on the RAM `data_out` one cycle after `rd_enb`, qualified by `rd_valid`.

## Interface
- `RAM_DEPTH`, 256: FIFO entries; must be a power of two and equal to the RAM depth.
- `ADDER_SIZE`, 8: address width; equals log2(`RAM_DEPTH`).
- `AFULL_THRESH`, 240: `almost_full` asserts when count >= this value.
- `AEMPTY_THRESH`, 16: `almost_empty` asserts when count <= this value.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  1  producer write request; data is valid on the RAM `data_in` in the same cycle.
- `pop`  in  1  consumer read request.
- `wr_enb`  out  1  RAM write enable; equals `push & ~full` (combinational).
- `rd_enb`  out  1  RAM read enable; equals `pop & ~empty` (combinational).
- `wr_addr`  out  `ADDER_SIZE`  RAM write address; low bits of the write pointer.
- `rd_addr`  out  `ADDER_SIZE`  RAM read address; low bits of the read pointer.
- `rd_valid`  out  1  RAM `data_out` holds popped data this cycle.
- `count`  out  `ADDER_SIZE+1`  current occupancy, 0..`RAM_DEPTH`.
- `full`, `empty`  out  1  occupancy flags (registered).
- `almost_full`, `almost_empty`  out  1  threshold flags (registered).
- `overflow`, `underflow`  out  1  sticky error flags.

## Operation
- Write and read pointers are `ADDER_SIZE+1` bits wide. The MSB is the wrap bit.
- Addresses are the pointer low bits. They wrap from `RAM_DEPTH-1` to 0.
- Accepted push (`wr_enb`=1): write pointer increments by 1.
- Accepted pop (`rd_enb`=1): read pointer increments by 1.
- Count update:
  - +1 on accepted push only.
  - -1 on accepted pop only.
  - Unchanged when both are accepted, or neither.
- `full` = (next count == `RAM_DEPTH`). `empty` = (next count == 0). Both are registered from the next-count value, so they are exact in the cycle following the update.
- Push while `full`:
  - The push is rejected, even if a pop is accepted in the same cycle.
  - No write occurs.
  - `overflow` sets.
- Pop while `empty`:
  - The pop is rejected, even if a push is accepted in the same cycle.
  - `rd_valid` stays 0.
  - `underflow` sets.
- `overflow` and `underflow` clear only on `reset`.
- Simultaneous push+pop with 0 < count < `RAM_DEPTH`:
  - Both are accepted; count is unchanged.
  - `wr_addr` and `rd_addr` may be equal only if count is 0 or `RAM_DEPTH`. In those cases one side is blocked, so no same-address read/write collision can occur.
- Reset values: pointers 0, `count` 0, `empty` 1, `full` 0, `almost_full` 0, `almost_empty` 1, `rd_valid` 0, `overflow` 0, `underflow` 0.
- Reset mid-operation: all state returns to the reset values on the next edge. RAM contents are ignored.
- While `reset` is high, `wr_enb` and `rd_enb` are forced to 0.

## Timing
- Write path: zero added latency. The RAM captures data at the edge where `wr_enb`=1.
- Read latency: 1 cycle. `rd_valid` is `rd_enb` registered, aligned with the RAM `data_out`.
- Flag and count latency: 1 cycle after the accepting edge.
- A pop issued the cycle after the first push into an empty FIFO is accepted, since `empty` has deasserted by then.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- Macro: `FIFO_CTRL_ALMOST_EN`.
- Defined: `almost_full` and `almost_empty` are computed as above, registered from the next count.
- Undefined:
  - Threshold logic is removed.
  - `almost_full` and `almost_empty` are tied to 0, including during reset.
  - The threshold parameters are ignored.

## Test plan
All scenarios use `RAM_DEPTH`=8, `ADDER_SIZE`=3, `AFULL_THRESH`=6, `AEMPTY_THRESH`=1.

- Reset check: hold `reset` for 2 cycles, then release -> `empty`=1, `count`=0, `full`=0, `almost_empty`=1, all errors 0, `wr_addr`=`rd_addr`=0.
- Fill: 8 consecutive pushes -> `wr_addr` runs 0..7.
  - `almost_full`=1 after the 6th push.
  - `full`=1 and `count`=8 after the 8th.
  - A 9th push gives `wr_enb`=0 and `overflow`=1.
- Drain: 8 pops from full -> `rd_addr` runs 0..7 and `rd_valid` is high one cycle after each `rd_enb`.
  - `empty`=1 after the 8th pop.
  - A 9th pop gives `rd_enb`=0, `underflow`=1, `rd_valid`=0.
- Wrap and simultaneous: preload 3 entries, then issue push+pop together for 10 cycles -> `count` stays 3, both addresses wrap 7->0, and the data order is preserved.
- Edge collisions:
  - Push+pop when `count`=8: only the pop is accepted; `count`=7 and `overflow`=1.
  - Push+pop when `count`=0: only the push is accepted; `count`=1 and `underflow`=1.
- Reset mid-burst: assert `reset` at `count`=5 -> all outputs return to reset values next cycle, including the sticky errors.
- Repeat the fill scenario with `FIFO_CTRL_ALMOST_EN` undefined -> `almost_full`=`almost_empty`=0 throughout.
